// File: rtl/hilo_read_ctrl_pkg.sv
// Shared function-code encodings and divider payload layout for the EX stage.
// Consumed by both the HI/LO read controller and the ALU control decoder.
package hilo_read_ctrl_pkg;

  localparam int unsigned FUNCT_CODE_W = 6;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned HILO_W       = 2 * DATA_W;
  localparam int unsigned CNT_W        = 7;

  // ALU / shift encodings
  localparam logic [FUNCT_CODE_W-1:0] FUNCT_SLL  = 6'd0;
  localparam logic [FUNCT_CODE_W-1:0] FUNCT_SRL  = 6'd2;
  localparam logic [FUNCT_CODE_W-1:0] FUNCT_SRA  = 6'd3;
  localparam logic [FUNCT_CODE_W-1:0] FUNCT_SLLV = 6'd4;
  localparam logic [FUNCT_CODE_W-1:0] FUNCT_SRLV = 6'd6;
  localparam logic [FUNCT_CODE_W-1:0] FUNCT_SRAV = 6'd7;
  localparam logic [FUNCT_CODE_W-1:0] FUNCT_ADD  = 6'd32;
  localparam logic [FUNCT_CODE_W-1:0] FUNCT_ADDU = 6'd33;
  localparam logic [FUNCT_CODE_W-1:0] FUNCT_SUB  = 6'd34;
  localparam logic [FUNCT_CODE_W-1:0] FUNCT_SUBU = 6'd35;
  localparam logic [FUNCT_CODE_W-1:0] FUNCT_AND  = 6'd36;
  localparam logic [FUNCT_CODE_W-1:0] FUNCT_OR   = 6'd37;
  localparam logic [FUNCT_CODE_W-1:0] FUNCT_XOR  = 6'd38;
  localparam logic [FUNCT_CODE_W-1:0] FUNCT_NOR  = 6'd39;
  localparam logic [FUNCT_CODE_W-1:0] FUNCT_SLT  = 6'd42;
  localparam logic [FUNCT_CODE_W-1:0] FUNCT_SLTU = 6'd43;

  // HI/LO and divide encodings
  localparam logic [FUNCT_CODE_W-1:0] FUNCT_MFHI = 6'd16;
  localparam logic [FUNCT_CODE_W-1:0] FUNCT_MFLO = 6'd18;
  localparam logic [FUNCT_CODE_W-1:0] FUNCT_DIVU = 6'd27;

  // Divider result bus: remainder lands in HI, quotient in LO
  typedef struct packed {
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] quo;
  } div_result_t;

endpackage

// File: rtl/hilo_regfile.sv
// HI/LO register pair: 64-bit write of {HI,LO}, 32-bit selectable read.
module hilo_regfile
  import hilo_read_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [HILO_W-1:0] wr_data,
  input  logic              rd_hi,
  output logic [DATA_W-1:0] rd_data_c,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out
);

  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  div_result_t       wr_s;

  assign wr_s = div_result_t'(wr_data);

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (wr_en) begin
      hi_d = wr_s.rem;
      lo_d = wr_s.quo;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign rd_data_c = rd_hi ? hi_q : lo_q;
  assign hi_out    = hi_q;
  assign lo_out    = lo_q;

endmodule

// File: rtl/hilo_read_ctrl.sv
// EX-stage controller for DIVU and MFHI/MFLO: launches the divider, waits with
// a timeout, commits the result to HI/LO and serves reads with forwarding.
module hilo_read_ctrl
  import hilo_read_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 40,
  parameter int unsigned FUNCT_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               issue,
  input  logic [FUNCT_W-1:0] funct,
  output logic               div_start,
  input  logic               div_done,
  input  logic [HILO_W-1:0]  div_result,
  output logic               stall,
  output logic [DATA_W-1:0]  read_data,
  output logic               read_valid,
  output logic [DATA_W-1:0]  hi_out,
  output logic [DATA_W-1:0]  lo_out,
  output logic               err
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              start_q, start_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              is_divu, is_mfhi, is_mflo, is_read;
  logic              busy, done_acc, accept;
  logic [DATA_W-1:0] rf_rd_data, fwd_data;
  div_result_t       res_s;

  assign is_divu  = issue & (funct == FUNCT_W'(FUNCT_DIVU));
  assign is_mfhi  = issue & (funct == FUNCT_W'(FUNCT_MFHI));
  assign is_mflo  = issue & (funct == FUNCT_W'(FUNCT_MFLO));
  assign is_read  = is_mfhi | is_mflo;
  assign busy     = (state_q == ST_BUSY);
  assign done_acc = busy & div_done;
  // An instruction proceeds when idle, or in the very cycle the divide lands
  assign accept   = ~busy | div_done;
  assign stall    = busy & (is_divu | is_read) & ~div_done;

  assign res_s    = div_result_t'(div_result);
  assign fwd_data = is_mfhi ? res_s.rem : res_s.quo;

  hilo_regfile u_regfile (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (done_acc),
    .wr_data   (div_result),
    .rd_hi     (is_mfhi),
    .rd_data_c (rf_rd_data),
    .hi_out    (hi_out),
    .lo_out    (lo_out)
  );

  // Next-state, counter and registered-output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    start_d  = 1'b0;
    rvalid_d = 1'b0;
    rdata_d  = rdata_q;
    err_d    = err_q;

    if (accept && is_read) begin
      rvalid_d = 1'b1;
      rdata_d  = done_acc ? fwd_data : rf_rd_data;
    end

    case (state_q)
      ST_IDLE: begin
        if (is_divu) begin
          start_d = 1'b1;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (div_done) begin
          if (is_divu) begin
            start_d = 1'b1;
            cnt_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      start_q  <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      start_q  <= start_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign div_start  = start_q;
  assign read_valid = rvalid_q;
  assign read_data  = rdata_q;
  assign err        = err_q;

endmodule

// File: doc/hilo_read_ctrl.md
HILO_READ_CTRL -- requirements
Module: hilo_read_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 40, maximum cycles to wait for divider completion before abort.
REQ-002 Parameter: FUNCT_W, default 6, width of the function code.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low; asserting it (low) clears all state immediately.
REQ-005 issue  input  1  EX-stage instruction valid this cycle.
REQ-006 funct  input  6  function code; DIVU=27, MFHI=16, MFLO=18; all other codes are ignored.
REQ-007 div_start  output  1  one-cycle pulse launching the divider on the dataA/dataB operands.
REQ-008 div_done  input  1  one-cycle pulse; div_result is valid in that cycle.
REQ-009 div_result  input  64  {remainder[63:32], quotient[31:0]}.
REQ-010 stall  output  1  combinational; holds the issuing stage.
REQ-011 read_data  output  32  registered HI or LO value.
REQ-012 read_valid  output  1  one-cycle pulse qualifying read_data.
REQ-013 hi_out, lo_out  output  32 each  current HI/LO contents.
REQ-014 err  output  1  sticky divider-timeout flag.

Function
REQ-015 The FSM SHALL have states IDLE and BUSY, with a 7-bit wait counter.
REQ-016 In IDLE, when issue=1 and funct=DIVU, the block SHALL pulse div_start for one cycle, clear the counter, and enter BUSY.
REQ-017 In IDLE, when issue=1 and funct=MFHI, the block SHALL drive read_data=HI and read_valid=1 on the next cycle; MFLO behaves the same way using LO.
REQ-018 In BUSY, the counter SHALL increment every cycle.
REQ-019 In BUSY, div_done=1 SHALL load HI=div_result[63:32] and LO=div_result[31:0], then return to IDLE.
REQ-020 stall SHALL equal (state==BUSY) & issue & funct in {DIVU,MFHI,MFLO} & !div_done; it SHALL never assert in IDLE.
REQ-021 Simultaneous div_done and MFHI/MFLO issue in BUSY: no stall; read_data SHALL return the newly written div_result half (forwarded), valid next cycle.
REQ-022 Simultaneous div_done and DIVU issue in BUSY: HI/LO SHALL update, div_start SHALL pulse next cycle, and the state SHALL remain BUSY with the counter cleared.
REQ-023 A div_done pulse received in IDLE SHALL be ignored; HI/LO remain unchanged.
REQ-024 When the counter reaches TIMEOUT in BUSY without div_done, the block SHALL set err, leave HI/LO unchanged, and go to IDLE.
REQ-025 Once set, err SHALL hold until reset.
REQ-026 Functions other than DIVU, MFHI, and MFLO SHALL never stall and SHALL cause no state change.
REQ-027 read_valid and div_start SHALL never be high for two consecutive cycles for a single instruction.

Reset
REQ-028 While reset=0, the block SHALL hold: state=IDLE, counter=0, HI=LO=0, read_data=0, read_valid=0, div_start=0, err=0; stall SHALL be 0.
REQ-029 Reset asserted mid-BUSY SHALL abandon the divide; a later div_done SHALL be ignored per REQ-023.
REQ-030 The first DIVU issue may be accepted on the first rising edge after reset deassertion.

Structure
REQ-031 The funct encodings (DIVU, MFHI, MFLO, plus the existing ALU/shift codes) SHALL live in a shared package reused by the ALU control.
REQ-032 The state enumeration SHALL be local to the module.
REQ-033 A single sub-module, hilo_regfile (the HI/LO pair with 64-bit write and 32-bit select-read), SHALL be instantiated.
REQ-034 The FSM, counter, and stall logic SHALL stay in the top module.

Verification
REQ-035 Reset release, then MFHI -> read_data=0x00000000 and read_valid=1 one cycle later, with no stall.
REQ-036 DIVU issued, div_done after 32 cycles with result 0x00000003_00000007, then MFLO -> read_data=0x00000007; MFHI -> 0x00000003.
REQ-037 MFHI issued 5 cycles after DIVU -> stall=1 until the div_done cycle, then read_data equals the new remainder, valid next cycle.
REQ-038 div_done coincident with DIVU issue -> HI/LO updated and div_start pulses next cycle, with stall=0 throughout.
REQ-039 DIVU with no div_done -> err=1 after 40 cycles and state back to IDLE; a later MFLO returns the old LO.
REQ-040 reset pulsed low at BUSY cycle 10, then div_done -> HI=LO=0, err=0, no stall.
